// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared phase encoding, turn codes and delay width for the snake tick scheduler
package snake_pkg;

    localparam int DELAY_W = 5;

    typedef enum logic [1:0] {
        PH_PLAY  = 2'b00,
        PH_HOLD  = 2'b01,
        PH_CLEAR = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'b00,
        TURN_RIGHT = 2'b01,
        TURN_LEFT  = 2'b10
    } turn_t;

endpackage

// File: rtl/snake_key_debounce.sv
// rtl/snake_key_debounce.sv - 2-flop key synchronizer, optional debounce (SNAKE_KEY_DEBOUNCE_EN), press edge
module snake_key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    logic sync_a;
    logic sync_b;
    logic lvl;
    logic lvl_prev;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
        end
    end

`ifdef SNAKE_KEY_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DW-1:0] stable_cnt;
    logic          deb_lvl;

    // Counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_lvl    <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_b == deb_lvl) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_lvl    <= sync_b;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign lvl = deb_lvl;
`else
    assign lvl = sync_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_prev <= 1'b1;
        end else begin
            lvl_prev <= lvl;
        end
    end

    assign press = lvl_prev & ~lvl;

endmodule

// File: rtl/snake_tick_sched.sv
// rtl/snake_tick_sched.sv - snake move-tick scheduler: period counter, turn latch, PLAY/HOLD/CLEAR FSM (SNAKE_KEY_DEBOUNCE_EN)
module snake_tick_sched
    import snake_pkg::*;
#(
    parameter int CLK_PER_UNIT = 20000,
    parameter int DELAY_INIT   = 20,
    parameter int DELAY_MIN    = 10,
    parameter int MSG_TICKS    = 20,
    parameter int DEB_CYCLES   = 50000
) (
    input  logic               clockInp,
    input  logic               rst,
    input  logic [1:0]         KEY,
    input  logic               game_over,
    input  logic               level_up,
    output logic               move_tick,
    output logic [1:0]         turn,
    output logic [1:0]         phase,
    output logic               msg_clear,
    output logic [DELAY_W-1:0] delay_cur
);

    localparam int CNT_W = 24;
    localparam int HW    = $clog2(MSG_TICKS + 1);

    phase_t             state;
    phase_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period;
    logic [DELAY_W-1:0] delay_r;
    logic [HW-1:0]      hold_cnt;
    turn_t              pend_turn;
    turn_t              press_code;
    logic               press_right;
    logic               press_left;
    logic               tick_evt;
    logic               play_evt;

    snake_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_right (
        .clk     (clockInp),
        .rst     (rst),
        .key_raw (KEY[0]),
        .press   (press_right)
    );

    snake_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_left (
        .clk     (clockInp),
        .rst     (rst),
        .key_raw (KEY[1]),
        .press   (press_left)
    );

    assign period     = CNT_W'(CLK_PER_UNIT) * CNT_W'(delay_r);
    assign tick_evt   = (cnt == period - 1'b1);
    assign play_evt   = (state == PH_PLAY) && (game_over || level_up);
    assign press_code = press_right ? TURN_RIGHT : (press_left ? TURN_LEFT : TURN_NONE);

    always_comb begin
        state_nxt = state;
        case (state)
            PH_PLAY:  if (game_over || level_up) state_nxt = PH_HOLD;
            PH_HOLD:  if (tick_evt && hold_cnt == HW'(MSG_TICKS - 1)) state_nxt = PH_CLEAR;
            PH_CLEAR: state_nxt = PH_PLAY;
            default:  state_nxt = PH_PLAY;
        endcase
    end

    always_ff @(posedge clockInp or posedge rst) begin
        if (rst) begin
            state     <= PH_PLAY;
            cnt       <= '0;
            delay_r   <= DELAY_W'(DELAY_INIT);
            hold_cnt  <= '0;
            pend_turn <= TURN_NONE;
        end else begin
            state <= state_nxt;

            // A delay change or a return to PLAY starts a fresh period.
            if (state == PH_CLEAR || play_evt || tick_evt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == PH_PLAY && game_over) begin
                delay_r <= DELAY_W'(DELAY_INIT);
            end else if (state == PH_PLAY && level_up && delay_r > DELAY_W'(DELAY_MIN)) begin
                delay_r <= delay_r - 1'b1;
            end

            if (state != PH_HOLD) begin
                hold_cnt <= '0;
            end else if (tick_evt) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            // On a tick the latch empties and any press in that cycle opens the next window.
            if (state != PH_PLAY || play_evt) begin
                pend_turn <= TURN_NONE;
            end else if (tick_evt || pend_turn == TURN_NONE) begin
                pend_turn <= press_code;
            end
        end
    end

    assign move_tick = (state == PH_PLAY) && tick_evt;
    assign turn      = move_tick ? pend_turn : TURN_NONE;
    assign phase     = state;
    assign msg_clear = (state == PH_CLEAR);
    assign delay_cur = delay_r;

endmodule

// File: tb/tb_snake_tick_sched.sv
// tb/tb_snake_tick_sched.sv - randomized self-checking bench for snake_tick_sched against a delay/turn reference model
module tb_snake_tick_sched;

    localparam int CPU = 4;
    localparam int DI  = 3;
    localparam int DM  = 2;
    localparam int MT  = 2;
    localparam int DC  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] KEY = 2'b11;
    logic       game_over = 1'b0;
    logic       level_up = 1'b0;
    logic       move_tick;
    logic [1:0] turn;
    logic [1:0] phase;
    logic       msg_clear;
    logic [4:0] delay_cur;

    int total  = 0;
    int passed = 0;
    int exp_delay = DI;

    always #5 clk = ~clk;

    snake_tick_sched #(
        .CLK_PER_UNIT (CPU),
        .DELAY_INIT   (DI),
        .DELAY_MIN    (DM),
        .MSG_TICKS    (MT),
        .DEB_CYCLES   (DC)
    ) dut (
        .clockInp  (clk),
        .rst       (rst),
        .KEY       (KEY),
        .game_over (game_over),
        .level_up  (level_up),
        .move_tick (move_tick),
        .turn      (turn),
        .phase     (phase),
        .msg_clear (msg_clear),
        .delay_cur (delay_cur)
    );

    task automatic wait_tick(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            n++;
            if (move_tick) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        rst = 1'b1;
        KEY = 2'b11;
        repeat (2) @(negedge clk);
        total++; if (phase !== 2'b00) $display("FAIL reset_phase: got %0d want 0", phase); else passed++;
        total++; if (move_tick !== 1'b0 || msg_clear !== 1'b0) $display("FAIL reset_pulses: move_tick %0b msg_clear %0b want 0 0", move_tick, msg_clear); else passed++;
        total++; if (turn !== 2'b00) $display("FAIL reset_turn: got %0d want 0", turn); else passed++;
        total++; if (delay_cur !== 5'(DI)) $display("FAIL reset_delay: got %0d want %0d", delay_cur, DI); else passed++;
        rst = 1'b0;
        exp_delay = DI;
        wait_tick(n, ok);
        total++; if (!ok || n + 1 != CPU * exp_delay) $display("FAIL first_tick: ok %0b edges %0d want %0d", ok, n + 1, CPU * exp_delay); else passed++;
    endtask

    task automatic test_free_run();
        int n;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n, ok);
            total++; if (!ok || n != CPU * exp_delay) $display("FAIL free_period: ok %0b got %0d want %0d", ok, n, CPU * exp_delay); else passed++;
            total++; if (turn !== 2'b00) $display("FAIL free_turn: got %0d want 0", turn); else passed++;
        end
    endtask

    task automatic test_turn_order();
        int n, off, gap, first;
        bit ok;
        logic [1:0] exp;
        for (int it = 0; it < 6; it++) begin
            off   = $urandom_range(0, 2);
            gap   = $urandom_range(0, 2);
            first = $urandom_range(0, 1);
            exp   = (gap == 0 || first == 0) ? 2'b01 : 2'b10;
            repeat (off) @(negedge clk);
            KEY[first] = 1'b0;
            if (gap == 0) KEY[1 - first] = 1'b0;
            else begin
                repeat (gap) @(negedge clk);
                KEY[1 - first] = 1'b0;
            end
            repeat (4) @(negedge clk);
            KEY = 2'b11;
            wait_tick(n, ok);
            total++; if (!ok || turn !== exp) $display("FAIL turn_order: ok %0b got %0d want %0d (first %0d gap %0d)", ok, turn, exp, first, gap); else passed++;
            wait_tick(n, ok);
            total++; if (!ok || turn !== 2'b00) $display("FAIL turn_cleared: ok %0b got %0d want 0", ok, turn); else passed++;
        end
    endtask

    task automatic test_held_key();
        int n;
        bit ok;
        @(negedge clk);
        KEY = 2'b00;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n, ok);
            total++; if (!ok || turn !== ((i == 0) ? 2'b01 : 2'b00)) $display("FAIL held_key tick %0d: ok %0b got %0d want %0d", i, ok, turn, (i == 0) ? 1 : 0); else passed++;
        end
        KEY = 2'b11;
        wait_tick(n, ok);
        total++; if (!ok || turn !== 2'b00) $display("FAIL held_release: ok %0b got %0d want 0", ok, turn); else passed++;
    endtask

    task automatic run_event(input bit go, input bit lu, input bit disturb);
        int n, off, hold, clr, bad, guard;
        bit ok;
        wait_tick(n, ok);
        total++; if (!ok || n != CPU * exp_delay) $display("FAIL pre_event_period: ok %0b got %0d want %0d", ok, n, CPU * exp_delay); else passed++;
        off = $urandom_range(1, CPU * exp_delay - 3);
        repeat (off) @(negedge clk);
        game_over = go;
        level_up  = lu;
        if (go) exp_delay = DI;
        else if (lu && exp_delay > DM) exp_delay = exp_delay - 1;
        @(negedge clk);
        game_over = 1'b0;
        level_up  = 1'b0;
        hold = 0; clr = 0; bad = 0; guard = 0;
        while (phase != 2'b00 && guard < 500) begin
            if (phase == 2'b01) hold++;
            if (msg_clear) clr++;
            if (move_tick) bad++;
            if (disturb && hold == 3) begin game_over = 1'b1; level_up = 1'b1; KEY = 2'b00; end
            if (disturb && hold == 4) begin game_over = 1'b0; level_up = 1'b0; end
            if (disturb && hold == 12) KEY = 2'b11;
            @(negedge clk);
            guard++;
        end
        KEY = 2'b11;
        total++; if (guard >= 500 || hold != MT * CPU * exp_delay) $display("FAIL hold_length: got %0d want %0d", hold, MT * CPU * exp_delay); else passed++;
        total++; if (clr != 1) $display("FAIL msg_clear_count: got %0d want 1", clr); else passed++;
        total++; if (bad != 0) $display("FAIL tick_outside_play: got %0d want 0", bad); else passed++;
        total++; if (delay_cur !== 5'(exp_delay)) $display("FAIL delay_after_event: got %0d want %0d", delay_cur, exp_delay); else passed++;
        wait_tick(n, ok);
        total++; if (!ok || n + 1 != CPU * exp_delay) $display("FAIL play_restart: ok %0b edges %0d want %0d", ok, n + 1, CPU * exp_delay); else passed++;
        total++; if (turn !== 2'b00) $display("FAIL turn_after_hold: got %0d want 0", turn); else passed++;
        wait_tick(n, ok);
        total++; if (!ok || n != CPU * exp_delay) $display("FAIL post_event_period: ok %0b got %0d want %0d", ok, n, CPU * exp_delay); else passed++;
    endtask

    task automatic test_level_up();
        run_event(1'b0, 1'b1, 1'b0);
        run_event(1'b0, 1'b1, 1'b1);
        run_event(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_both_events();
        run_event(1'b0, 1'b1, 1'b0);
        run_event(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        int n, clr;
        bit ok;
        wait_tick(n, ok);
        repeat (2) @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (phase !== 2'b01) $display("FAIL hold_entered: got %0d want 1", phase); else passed++;
        rst = 1'b1;
        #1;
        total++; if (phase !== 2'b00 || msg_clear !== 1'b0 || move_tick !== 1'b0) $display("FAIL async_reset: phase %0d msg_clear %0b move_tick %0b want 0 0 0", phase, msg_clear, move_tick); else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_delay = DI;
        n = 0; clr = 0;
        while (!move_tick && n < 300) begin
            @(negedge clk);
            n++;
            if (msg_clear) clr++;
        end
        total++; if (!move_tick || n + 1 != CPU * exp_delay) $display("FAIL reset_hold_tick: edges %0d want %0d", n + 1, CPU * exp_delay); else passed++;
        total++; if (clr != 0) $display("FAIL reset_hold_clear: got %0d want 0", clr); else passed++;
    endtask

    task automatic test_debounce();
        int n;
        bit ok;
        logic [1:0] exp_glitch;
`ifdef SNAKE_KEY_DEBOUNCE_EN
        exp_glitch = 2'b00;
`else
        exp_glitch = 2'b01;
`endif
        @(negedge clk);
        KEY[0] = 1'b0;
        repeat (2) @(negedge clk);
        KEY[0] = 1'b1;
        wait_tick(n, ok);
        total++; if (!ok || turn !== exp_glitch) $display("FAIL glitch_turn: ok %0b got %0d want %0d", ok, turn, exp_glitch); else passed++;
        @(negedge clk);
        KEY[1] = 1'b0;
        repeat (5) @(negedge clk);
        KEY[1] = 1'b1;
        wait_tick(n, ok);
        total++; if (!ok || turn !== 2'b10) $display("FAIL long_press_turn: ok %0b got %0d want 2", ok, turn); else passed++;
        wait_tick(n, ok);
        total++; if (!ok || turn !== 2'b00) $display("FAIL long_press_once: ok %0b got %0d want 0", ok, turn); else passed++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_turn_order();
        test_held_key();
        test_level_up();
        test_both_events();
        test_reset_in_hold();
        test_debounce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
